regfile_wb_arbiter: RTL

Write-back arbiter that sits directly upstream of the register file and drives its single write port. It merges single-cycle ALU results, which have priority and no backpressure, with long-latency load/multiply-divide results, which arrive through a valid/ready handshake. Long-latency results are buffered in a small FIFO. A starvation counter guarantees the FIFO drains by briefly stalling the ALU stream.

---
 rtl/regfile_wb_arbiter.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter driving the register file's single write port.
// ALU results have priority; long-latency results queue in a FIFO guarded by a starvation counter.
module regfile_wb_arbiter #(
    parameter int ADDR       = 5,
    parameter int BUS_W      = 32,
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 3
) (
    input  logic                     reloj,
    input  logic                     reset,
    input  logic                     alu_valid,
    input  logic [ADDR-1:0]          alu_rd,
    input  logic [BUS_W-1:0]         alu_data,
    input  logic                     lsu_valid,
    output logic                     lsu_ready,
    input  logic [ADDR-1:0]          lsu_rd,
    input  logic [BUS_W-1:0]         lsu_data,
    output logic [ADDR-1:0]          rd_addr,
    output logic [BUS_W-1:0]         rd_w_data,
    output logic                     reg_write,
    output logic                     alu_stall,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     err_alu_drop
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    logic [ADDR-1:0]  r_mem_rd   [DEPTH];
    logic [BUS_W-1:0] r_mem_data [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic [SW-1:0]    r_starve;
    logic             r_alu_stall;
    logic             r_err;
    logic             r_reg_write;
    logic [ADDR-1:0]  r_rd_addr;
    logic [BUS_W-1:0] r_wdata;

    logic             w_fifo_ne;
    logic             w_ready;
    logic             w_push;
    logic             w_alu_req;
    logic             w_grant_fifo;
    logic             w_grant_alu;
    logic [SW-1:0]    w_starve_next;
    logic [CW-1:0]    w_count_next;

    assign w_fifo_ne = (r_count != '0);
    assign w_ready   = (r_count < FULL_CNT);
    // A zero-destination result completes its handshake but is never stored.
    assign w_push    = lsu_valid && w_ready && (lsu_rd != '0);
    assign w_alu_req = alu_valid && (alu_rd != '0) && !r_alu_stall;

    always_comb begin
        w_grant_fifo = 1'b0;
        w_grant_alu  = 1'b0;
        if (r_alu_stall && w_fifo_ne) begin
            w_grant_fifo = 1'b1;
        end else if (w_alu_req) begin
            w_grant_alu = 1'b1;
        end else if (w_fifo_ne) begin
            w_grant_fifo = 1'b1;
        end
    end

    always_comb begin
        w_starve_next = r_starve;
        if (!w_fifo_ne || w_grant_fifo) begin
            w_starve_next = '0;
        end else if (r_starve != STARVE_LIM) begin
            w_starve_next = r_starve + 1'b1;
        end
    end

    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_grant_fifo) begin
            w_count_next = r_count + 1'b1;
        end else if (!w_push && w_grant_fifo) begin
            w_count_next = r_count - 1'b1;
        end
    end

    always_ff @(posedge reloj) begin
        if (w_push) begin
            r_mem_rd[r_wr_ptr]   <= lsu_rd;
            r_mem_data[r_wr_ptr] <= lsu_data;
        end
    end

    // Stall is raised on the same edge the counter hits its limit, so it lasts exactly the grant cycle.
    always_ff @(posedge reloj or negedge reset) begin
        if (!reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_starve    <= '0;
            r_alu_stall <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_grant_fifo) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count     <= w_count_next;
            r_starve    <= w_starve_next;
            r_alu_stall <= (w_starve_next == STARVE_LIM);
            r_err       <= r_err || (alu_valid && r_alu_stall);
        end
    end

    always_ff @(posedge reloj or negedge reset) begin
        if (!reset) begin
            r_reg_write <= 1'b0;
            r_rd_addr   <= '0;
            r_wdata     <= '0;
        end else begin
            r_reg_write <= w_grant_fifo || w_grant_alu;
            if (w_grant_fifo) begin
                r_rd_addr <= r_mem_rd[r_rd_ptr];
                r_wdata   <= r_mem_data[r_rd_ptr];
            end else if (w_grant_alu) begin
                r_rd_addr <= alu_rd;
                r_wdata   <= alu_data;
            end
        end
    end

    assign lsu_ready    = w_ready;
    assign rd_addr      = r_rd_addr;
    assign rd_w_data    = r_wdata;
    assign reg_write    = r_reg_write;
    assign alu_stall    = r_alu_stall;
    assign fifo_count   = r_count;
    assign err_alu_drop = r_err;

endmodule
